// File: rtl/csm_mp_lockmem_pkg.sv
// Shared types and default sizing for the multi-port lockable CSM memory.
package csm_mp_lockmem_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_HOLD    = 2'd2,
        OP_RELEASE = 2'd3
    } csm_op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_HELD      = 2'd1,
        ERR_NOT_OWNER = 2'd2,
        ERR_CONFLICT  = 2'd3
    } csm_err_e;

    localparam int DEF_NUM_PORTS    = 2;
    localparam int DEF_ADDR_W       = 3;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_HOLD_TIMEOUT = 64;

endpackage

// File: rtl/csm_mp_lockmem_if.sv
// Per-port request/response bundle between the port masters and the lockable memory.
interface csm_mp_lockmem_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8
);
    logic [NUM_PORTS-1:0]             req_valid;
    logic [NUM_PORTS-1:0][1:0]        req_op;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]             resp_valid;
    logic [NUM_PORTS-1:0][DATA_W-1:0] resp_rdata;
    logic [NUM_PORTS-1:0][1:0]        resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/csm_mp_lockmem_rr_arbiter.sv
// Round-robin pick of one requester, searching upward from ptr and wrapping.
module csm_mp_lockmem_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt
);
    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

    logic [NUM_PORTS-1:0] mask;
    logic [NUM_PORTS-1:0] masked;

    // Requests at or above ptr take priority; otherwise wrap to the lowest request.
    assign mask   = ~((ONE << ptr) - ONE);
    assign masked = req & mask;
    assign gnt    = (|masked) ? (masked & (~masked + ONE)) : (req & (~req + ONE));

endmodule

// File: rtl/csm_mp_lockmem.sv
// Shared register-file memory with per-location hold/ownership, round-robin conflict
// resolution among NUM_PORTS channels and hold auto-release after HOLD_TIMEOUT cycles.
module csm_mp_lockmem
    import csm_mp_lockmem_pkg::*;
#(
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    csm_mp_lockmem_if.slave         bus,
    output logic [(2**ADDR_W)-1:0]  hold_vec,
    output logic                    timeout_pulse
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(HOLD_TIMEOUT - 1);

    logic [DEPTH-1:0][DATA_W-1:0]     mem_q, mem_d;
    logic [DEPTH-1:0]                 held_q, held_d;
    logic [DEPTH-1:0][PTR_W-1:0]      owner_q, owner_d;
    logic [DEPTH-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic                             tpulse_q, tpulse_d;
    logic [NUM_PORTS-1:0]             resp_valid_q, resp_valid_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [NUM_PORTS-1:0][1:0]        resp_err_q, resp_err_d;

    logic [NUM_PORTS-1:0][1:0]        chk_err;
    logic [NUM_PORTS-1:0]             pass_wr;
    logic [NUM_PORTS-1:0]             win;
    logic [DEPTH-1:0][NUM_PORTS-1:0]  cand;
    logic [DEPTH-1:0][NUM_PORTS-1:0]  gnt;
    logic [DEPTH-1:0]                 conflict;
    logic [DEPTH-1:0]                 touched;

    // Lock check against start-of-cycle state. A RELEASE by anyone but the
    // current owner reports NOT_OWNER rather than HELD.
    always_comb begin
        chk_err = '0;
        pass_wr = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.req_valid[p]) begin
                if (bus.req_op[p] == OP_RELEASE &&
                    !(held_q[bus.req_addr[p]] && owner_q[bus.req_addr[p]] == PTR_W'(p)))
                    chk_err[p] = ERR_NOT_OWNER;
                else if (held_q[bus.req_addr[p]] && owner_q[bus.req_addr[p]] != PTR_W'(p))
                    chk_err[p] = ERR_HELD;
                else if (bus.req_op[p] != OP_READ)
                    pass_wr[p] = 1'b1;
            end
        end
    end

    for (genvar a = 0; a < DEPTH; a++) begin : g_addr
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign cand[a][p] = pass_wr[p] && (bus.req_addr[p] == ADDR_W'(a));
        end

        csm_mp_lockmem_rr_arbiter #(
            .NUM_PORTS (NUM_PORTS),
            .PTR_W     (PTR_W)
        ) u_arb (
            .req (cand[a]),
            .ptr (rr_ptr_q),
            .gnt (gnt[a])
        );

        assign conflict[a] = ($countones(cand[a]) > 1);
    end

    always_comb begin
        mem_d        = mem_q;
        held_d       = held_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        tpulse_d     = 1'b0;
        touched      = '0;
        win          = '0;
        resp_valid_d = bus.req_valid;
        resp_rdata_d = '0;
        resp_err_d   = '0;

        for (int p = 0; p < NUM_PORTS; p++) begin
            win[p] = pass_wr[p] && gnt[bus.req_addr[p]][p];
            if (bus.req_valid[p]) begin
                resp_err_d[p] = chk_err[p];
                if (pass_wr[p] && !win[p])
                    resp_err_d[p] = ERR_CONFLICT;
                if (chk_err[p] == ERR_NONE && bus.req_op[p] == OP_READ) begin
                    resp_rdata_d[p]            = mem_q[bus.req_addr[p]];
                    touched[bus.req_addr[p]]   = 1'b1;
                end
                if (win[p]) begin
                    touched[bus.req_addr[p]] = 1'b1;
                    case (bus.req_op[p])
                        OP_WRITE: mem_d[bus.req_addr[p]] = bus.req_wdata[p];
                        OP_HOLD: begin
                            held_d[bus.req_addr[p]]  = 1'b1;
                            owner_d[bus.req_addr[p]] = PTR_W'(p);
                        end
                        OP_RELEASE: held_d[bus.req_addr[p]] = 1'b0;
                        default: ;
                    endcase
                end
            end
        end

        // With several conflicting addresses, the lowest one steers the pointer.
        for (int a = DEPTH - 1; a >= 0; a--) begin
            if (conflict[a]) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (gnt[a][p])
                        rr_ptr_d = (p == NUM_PORTS - 1) ? '0 : PTR_W'(p + 1);
                end
            end
        end

        // An owner access in the expiry cycle keeps the hold alive.
        for (int a = 0; a < DEPTH; a++) begin
            if (!held_q[a] || touched[a]) begin
                cnt_d[a] = '0;
            end else if (HOLD_TIMEOUT > 0) begin
                if (cnt_q[a] == CNT_EXP) begin
                    held_d[a] = 1'b0;
                    cnt_d[a]  = '0;
                    tpulse_d  = 1'b1;
                end else if (cnt_q[a] != CNT_MAX) begin
                    cnt_d[a] = cnt_q[a] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q        <= '0;
            held_q       <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            tpulse_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= '0;
        end else begin
            mem_q        <= mem_d;
            held_q       <= held_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            tpulse_q     <= tpulse_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign hold_vec       = held_q;
    assign timeout_pulse  = tpulse_q;

endmodule

// File: tb/tb_csm_mp_lockmem.sv
// Directed scenarios plus random traffic against an address-level reference model of the lock memory.
module tb_csm_mp_lockmem;
    import csm_mp_lockmem_pkg::*;

    localparam int NP    = 3;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int TO    = 4;
    localparam int DEPTH = 2**AW;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [DEPTH-1:0] hold_vec;
    logic             timeout_pulse;

    csm_mp_lockmem_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    csm_mp_lockmem #(
        .NUM_PORTS    (NP),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .HOLD_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .hold_vec      (hold_vec),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: plain arrays, age = edges since the last owner touch.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_held[DEPTH];
    int            m_owner[DEPTH];
    int            m_age [DEPTH];
    int            m_rr;

    logic [NP-1:0]         exp_vld;
    logic [NP-1:0][DW-1:0] exp_rd;
    logic [NP-1:0][1:0]    exp_err;
    logic [DEPTH-1:0]      exp_hold;
    logic                  exp_pulse;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < DEPTH; d++) begin
            m_mem[d] = '0; m_held[d] = 0; m_owner[d] = 0; m_age[d] = 0;
        end
        m_rr = 0;
    endtask

    task automatic model_step();
        bit contend[NP];
        bit touched[DEPTH];
        bit held0[DEPTH];
        int a, op, n, w, q;
        bit seen;
        exp_vld = bus.req_valid; exp_rd = '0; exp_err = '0; exp_pulse = 1'b0;
        seen = 0;
        for (int d = 0; d < DEPTH; d++) begin held0[d] = m_held[d]; touched[d] = 0; end
        for (int p = 0; p < NP; p++) begin
            contend[p] = 0;
            if (bus.req_valid[p]) begin
                a  = int'(bus.req_addr[p]);
                op = int'(bus.req_op[p]);
                if (op == 3 && !(m_held[a] && m_owner[a] == p)) exp_err[p] = 2'd2;
                else if (m_held[a] && m_owner[a] != p) exp_err[p] = 2'd1;
                else if (op == 0) begin exp_rd[p] = m_mem[a]; touched[a] = 1; end
                else contend[p] = 1;
            end
        end
        for (int d = 0; d < DEPTH; d++) begin
            n = 0; w = -1;
            for (int k = 0; k < NP; k++) begin
                q = (m_rr + k) % NP;
                if (contend[q] && int'(bus.req_addr[q]) == d) begin
                    n++;
                    if (w < 0) w = q;
                end
            end
            if (n > 0) begin
                for (int k = 0; k < NP; k++)
                    if (contend[k] && int'(bus.req_addr[k]) == d && k != w) exp_err[k] = 2'd3;
                if (n > 1 && !seen) begin seen = 1; m_rr = (w + 1) % NP; end
                touched[d] = 1;
                case (int'(bus.req_op[w]))
                    1: m_mem[d] = bus.req_wdata[w];
                    2: begin m_held[d] = 1; m_owner[d] = w; m_age[d] = 0; end
                    3: m_held[d] = 0;
                    default: ;
                endcase
            end
        end
        for (int d = 0; d < DEPTH; d++) begin
            if (held0[d]) begin
                if (touched[d]) m_age[d] = 0;
                else begin
                    m_age[d]++;
                    if (TO > 0 && m_age[d] >= TO) begin m_held[d] = 0; exp_pulse = 1'b1; end
                end
            end
        end
        for (int d = 0; d < DEPTH; d++) exp_hold[d] = m_held[d];
    endtask

    task automatic clr();
        bus.req_valid = '0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    endtask

    task automatic drv(input int p, input csm_op_e op, input int a, input int wd);
        bus.req_valid[p] = 1'b1;
        bus.req_op[p]    = op;
        bus.req_addr[p]  = AW'(a);
        bus.req_wdata[p] = DW'(wd);
    endtask

    task automatic step();
        model_step();
        @(posedge clk); #1;
        chk("resp_valid", bus.resp_valid, exp_vld);
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        chk("resp_err", bus.resp_err, exp_err);
        chk("hold_vec", hold_vec, exp_hold);
        chk("timeout_pulse", timeout_pulse, exp_pulse);
        clr();
    endtask

    initial begin
        int k;
        clr();
        model_reset();
        @(posedge clk); #1;
        chk("rst_valid", bus.resp_valid, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_err", bus.resp_err, 0);
        chk("rst_hold", hold_vec, 0);
        chk("rst_pulse", timeout_pulse, 0);
        @(negedge clk); reset_n = 1'b1;

        // write then read back with one-cycle latency
        drv(0, OP_WRITE, 3, 'hA5); step();
        chk("t1_wr_err", bus.resp_err[0], ERR_NONE);
        drv(0, OP_READ, 3, 0); step();
        chk("t1_rd_vld", bus.resp_valid[0], 1);
        chk("t1_rd_data", bus.resp_rdata[0], 'hA5);

        // hold blocks other ports
        drv(0, OP_HOLD, 2, 0); step();
        chk("t2_hold_vec", hold_vec[2], 1);
        drv(1, OP_WRITE, 2, 'h11); step();
        chk("t2_held_err", bus.resp_err[1], ERR_HELD);
        drv(0, OP_READ, 2, 0); step();
        chk("t2_owner_rd", bus.resp_rdata[0], 'h00);
        drv(1, OP_RELEASE, 2, 0); step();
        chk("t2_rel_err", bus.resp_err[1], ERR_NOT_OWNER);

        // same-cycle write conflict, pointer rotates
        drv(0, OP_WRITE, 5, 'hFF); drv(1, OP_WRITE, 5, 'h00); step();
        chk("t3a_p0_err", bus.resp_err[0], ERR_NONE);
        chk("t3a_p1_err", bus.resp_err[1], ERR_CONFLICT);
        drv(0, OP_READ, 5, 0); step();
        chk("t3a_mem", bus.resp_rdata[0], 'hFF);
        drv(0, OP_WRITE, 5, 'hFF); drv(1, OP_WRITE, 5, 'h00); step();
        chk("t3b_p0_err", bus.resp_err[0], ERR_CONFLICT);
        chk("t3b_p1_err", bus.resp_err[1], ERR_NONE);
        drv(0, OP_READ, 5, 0); step();
        chk("t3b_mem", bus.resp_rdata[0], 'h00);

        // read-before-write in the same cycle
        drv(0, OP_WRITE, 1, 'h3C); drv(1, OP_READ, 1, 0); step();
        chk("t4_rbw", bus.resp_rdata[1], 'h00);
        drv(1, OP_READ, 1, 0); step();
        chk("t4_after", bus.resp_rdata[1], 'h3C);

        // abandoned hold times out
        drv(1, OP_HOLD, 7, 0); step();
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (timeout_pulse) begin k = i; break; end
        end
        chk("t5_timeout_cycles", k, TO);
        chk("t5_hold_cleared", hold_vec[7], 0);
        drv(0, OP_WRITE, 7, 'h77); step();
        chk("t5_wr_after", bus.resp_err[0], ERR_NONE);

        // reset mid-operation drops responses and locks
        drv(0, OP_HOLD, 4, 0); step();
        chk("t6_held", hold_vec[4], 1);
        drv(0, OP_READ, 4, 0);
        #2 reset_n = 1'b0; #1;
        chk("t6_rst_vld", bus.resp_valid, 0);
        chk("t6_rst_hold", hold_vec, 0);
        model_reset();
        clr();
        @(negedge clk); @(negedge clk); reset_n = 1'b1;
        drv(1, OP_WRITE, 4, 'h42); step();
        chk("t6_wr_after", bus.resp_err[1], ERR_NONE);

        // random traffic, biased toward a few addresses to force conflicts
        for (int it = 0; it < 1500; it++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 9) < 7)
                    drv(p, csm_op_e'($urandom_range(0, 3)),
                        $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1)),
                        int'($urandom_range(0, 255)));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
